// File: rtl/hsv_effect_engine_if.sv
// hsv_effect_engine_if
//   Command channel into the HSV effect engine.
//   master : command decoder side (drives cmd_valid/cmd_ch/cmd_data)
//   slave  : effect engine side (drives cmd_ready/cmd_err)
// Signals:
//   cmd_valid  command word present
//   cmd_ready  engine can accept a command
//   cmd_ch     target channel (CH_W bits)
//   cmd_data   {val[26:19], sat[18:11], hue[10:2], mode[1:0]}
//   cmd_err    one-cycle pulse, accepted command addressed a missing channel
interface hsv_effect_engine_if #(
  parameter int CH_W = 1
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic [26:0]     cmd_data;
  logic            cmd_err;

  modport master (
    output cmd_valid, cmd_ch, cmd_data,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_data,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/hsv_effect_engine.sv
// hsv_effect_engine
//   Multi-channel HSV colour-effect sequencer. Each channel holds a mode and
//   H/S/V registers loaded by command words, and animates hue (STEP, SWEEP)
//   or value (BREATHE) on its own tick counter.
//
// Build option:
//   HSV_BREATHE_EN  defined   : mode 3 = BREATHE (value ramps base V -> 0 -> base V)
//                   undefined : mode 3 = DIM (value forced to DIM_VAL, no ticks)
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   cmd      hsv_effect_engine_if.slave command channel
//   hue_o    channel n hue at [9n+8:9n], 0..359
//   sat_o    channel n saturation at [8n+7:8n]
//   val_o    channel n value at [8n+7:8n]
//   upd_o    per-channel one-cycle pulse when that channel's outputs reload
//
// Control FSM:
//   state   | meaning
//   ST_INIT | just out of reset, commands not yet accepted
//   ST_RUN  | cmd_ready high, commands accepted every cycle
module hsv_effect_engine #(
  parameter int CHANNELS   = 2,
  parameter int SLOW_TICKS = 10_000_000,
  parameter int FAST_TICKS = 500_000,
  parameter int STEP_SLOW  = 60,
  parameter int STEP_FAST  = 1,
  parameter int DIM_VAL    = 30,
  parameter int CNT_W      = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  hsv_effect_engine_if.slave        cmd,
  output logic [9*CHANNELS-1:0]     hue_o,
  output logic [8*CHANNELS-1:0]     sat_o,
  output logic [8*CHANNELS-1:0]     val_o,
  output logic [CHANNELS-1:0]       upd_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] SLOW_M1     = CNT_W'(SLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_M1     = CNT_W'(FAST_TICKS - 1);
  localparam logic [9:0]       STEP_SLOW_W = 10'(STEP_SLOW);
  localparam logic [9:0]       STEP_FAST_W = 10'(STEP_FAST);
  localparam logic [7:0]       DIM_VAL_W   = 8'(DIM_VAL);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_STEP   = 2'd1;
  localparam logic [1:0] MODE_SWEEP  = 2'd2;
  localparam logic [1:0] MODE_3      = 2'd3;

`ifdef HSV_BREATHE_EN
  localparam logic MODE3_ANIM = 1'b1;
`else
  localparam logic MODE3_ANIM = 1'b0;
`endif

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state_q, state_d;

  logic             cmd_err_q, cmd_err_d;
  logic [1:0]       mode_q  [CHANNELS];
  logic [1:0]       mode_d  [CHANNELS];
  logic [8:0]       hue_q   [CHANNELS];
  logic [8:0]       hue_d   [CHANNELS];
  logic [7:0]       sat_q   [CHANNELS];
  logic [7:0]       sat_d   [CHANNELS];
  logic [7:0]       val_q   [CHANNELS];
  logic [7:0]       val_d   [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] upd_q, upd_d;
`ifdef HSV_BREATHE_EN
  // Base V is only needed as the breathe ceiling; hue and sat never move
  // away from their loaded values in BREATHE, so no separate base copy.
  logic [7:0]       base_v_q [CHANNELS];
  logic [7:0]       base_v_d [CHANNELS];
  logic             dir_up_q [CHANNELS];
  logic             dir_up_d [CHANNELS];
`endif

  logic             accept;
  logic             ch_ok;
  logic [8:0]       cmd_hue_raw;
  logic [8:0]       cmd_hue;
  logic [7:0]       cmd_sat;
  logic [7:0]       cmd_val;
  logic [1:0]       cmd_mode;
  logic             anim     [CHANNELS];
  logic             tick     [CHANNELS];
  logic [CNT_W-1:0] period_m1 [CHANNELS];

  // Both operands are below 360, so a single conditional subtract wraps.
  function automatic logic [8:0] hue_add(input logic [8:0] h, input logic [9:0] inc);
    logic [9:0] sum;
    sum = {1'b0, h} + inc;
    if (sum >= 10'd360) sum = sum - 10'd360;
    return sum[8:0];
  endfunction

  assign cmd_hue_raw = cmd.cmd_data[10:2];
  assign cmd_sat     = cmd.cmd_data[18:11];
  assign cmd_val     = cmd.cmd_data[26:19];
  assign cmd_mode    = cmd.cmd_data[1:0];
  assign cmd_hue     = (cmd_hue_raw >= 9'd360) ? (cmd_hue_raw - 9'd360) : cmd_hue_raw;

  assign cmd.cmd_ready = (state_q == ST_RUN);
  assign cmd.cmd_err   = cmd_err_q;
  assign upd_o         = upd_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    accept    = cmd.cmd_valid && (state_q == ST_RUN);
    ch_ok     = accept && ({1'b0, cmd.cmd_ch} < (CH_W + 1)'(CHANNELS));
    cmd_err_d = accept && !ch_ok;
    upd_d     = '0;

    for (int c = 0; c < CHANNELS; c++) begin
      mode_d[c]    = mode_q[c];
      hue_d[c]     = hue_q[c];
      sat_d[c]     = sat_q[c];
      val_d[c]     = val_q[c];
      cnt_d[c]     = cnt_q[c];
`ifdef HSV_BREATHE_EN
      base_v_d[c]  = base_v_q[c];
      dir_up_d[c]  = dir_up_q[c];
`endif
      anim[c]      = (mode_q[c] == MODE_STEP) || (mode_q[c] == MODE_SWEEP) ||
                     (MODE3_ANIM && (mode_q[c] == MODE_3));
      period_m1[c] = (mode_q[c] == MODE_STEP) ? SLOW_M1 : FAST_M1;
      tick[c]      = 1'b0;

      if (anim[c]) begin
        if (cnt_q[c] == period_m1[c]) begin
          tick[c]  = 1'b1;
          cnt_d[c] = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end

      // A command on this channel overrides any tick landing the same cycle.
      if (ch_ok && (cmd.cmd_ch == CH_W'(c))) begin
        mode_d[c] = cmd_mode;
        hue_d[c]  = cmd_hue;
        sat_d[c]  = cmd_sat;
        val_d[c]  = cmd_val;
        cnt_d[c]  = '0;
        upd_d[c]  = 1'b1;
`ifdef HSV_BREATHE_EN
        base_v_d[c] = cmd_val;
        dir_up_d[c] = 1'b0;
`else
        if (cmd_mode == MODE_3) val_d[c] = DIM_VAL_W;
`endif
      end else if (tick[c]) begin
        upd_d[c] = 1'b1;
        case (mode_q[c])
          MODE_STEP:  hue_d[c] = hue_add(hue_q[c], STEP_SLOW_W);
          MODE_SWEEP: hue_d[c] = hue_add(hue_q[c], STEP_FAST_W);
`ifdef HSV_BREATHE_EN
          MODE_3: begin
            if (!dir_up_q[c]) begin
              val_d[c] = (val_q[c] == 8'd0) ? 8'd0 : (val_q[c] - 8'd1);
              if (val_d[c] == 8'd0) dir_up_d[c] = 1'b1;
            end else begin
              val_d[c] = (val_q[c] >= base_v_q[c]) ? val_q[c] : (val_q[c] + 8'd1);
              if (val_d[c] >= base_v_q[c]) dir_up_d[c] = 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cmd_err_q <= 1'b0;
      upd_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]   <= MODE_STATIC;
        hue_q[c]    <= 9'd0;
        sat_q[c]    <= 8'd80;
        val_q[c]    <= 8'd80;
        cnt_q[c]    <= '0;
`ifdef HSV_BREATHE_EN
        base_v_q[c] <= 8'd80;
        dir_up_q[c] <= 1'b0;
`endif
      end
    end else begin
      state_q   <= state_d;
      cmd_err_q <= cmd_err_d;
      upd_q     <= upd_d;
      mode_q    <= mode_d;
      hue_q     <= hue_d;
      sat_q     <= sat_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
`ifdef HSV_BREATHE_EN
      base_v_q  <= base_v_d;
      dir_up_q  <= dir_up_d;
`endif
    end
  end

  always_comb begin
    hue_o = '0;
    sat_o = '0;
    val_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hue_o[9*c +: 9] = hue_q[c];
      sat_o[8*c +: 8] = sat_q[c];
      val_o[8*c +: 8] = val_q[c];
    end
  end

endmodule

// File: tb/tb_hsv_effect_engine.sv
module tb_hsv_effect_engine;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;
  localparam int SLOW     = 10;
  localparam int FAST     = 4;
  localparam int DIM      = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hsv_effect_engine_if #(.CH_W(CH_W)) cmd_if ();

  logic [9*CHANNELS-1:0] hue_o;
  logic [8*CHANNELS-1:0] sat_o;
  logic [8*CHANNELS-1:0] val_o;
  logic [CHANNELS-1:0]   upd_o;

  hsv_effect_engine #(
    .CHANNELS(CHANNELS), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST),
    .STEP_SLOW(60), .STEP_FAST(1), .DIM_VAL(DIM), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if),
    .hue_o(hue_o), .sat_o(sat_o), .val_o(val_o), .upd_o(upd_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int hue;
    int sat;
    int val;
  } exp_t;

  exp_t sb_q [CHANNELS][$];
  exp_t mon_e;
  bit   sb_en = 1'b0;

  function automatic int hue_of(int c);
    return int'(hue_o[9*c +: 9]);
  endfunction
  function automatic int sat_of(int c);
    return int'(sat_o[8*c +: 8]);
  endfunction
  function automatic int val_of(int c);
    return int'(val_o[8*c +: 8]);
  endfunction

  task automatic sb_push(input int c, input int n, input int h, input int s, input int v);
    exp_t e;
    e.cyc = n; e.hue = h; e.sat = s; e.val = v;
    sb_q[c].push_back(e);
  endtask

  // Scoreboard: every upd_o pulse must match the next predicted reload.
  always @(negedge clk) begin
    if (sb_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (upd_o[c]) begin
          checks++;
          if (sb_q[c].size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_upd ch%0d cyc %0d hue %0d val %0d", c, cyc, hue_of(c), val_of(c));
          end else begin
            mon_e = sb_q[c].pop_front();
            if (mon_e.cyc !== cyc || hue_of(c) !== mon_e.hue ||
                sat_of(c) !== mon_e.sat || val_of(c) !== mon_e.val) begin
              errors++;
              $display("FAIL sb_upd ch%0d got cyc %0d h %0d s %0d v %0d exp cyc %0d h %0d s %0d v %0d",
                       c, cyc, hue_of(c), sat_of(c), val_of(c),
                       mon_e.cyc, mon_e.hue, mon_e.sat, mon_e.val);
            end
          end
        end
      end
    end
  end

  // Called at a negedge; the command is accepted at the next posedge and the
  // task returns at the negedge right after it.
  task automatic cmd_send(input int c, input int m, input int h, input int s, input int v);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = CH_W'(c);
    cmd_if.cmd_data  = {8'(v), 8'(s), 9'(h), 2'(m)};
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = 2'd0;
    cmd_if.cmd_data  = {8'd1, 8'd2, 9'd3, 2'd1};
    repeat (3) @(negedge clk);
    for (int c = 0; c < CHANNELS; c++) begin
      checks++;
      if (hue_of(c) !== 0 || sat_of(c) !== 80 || val_of(c) !== 80) begin
        errors++;
        $display("FAIL reset_hsv ch%0d got %0d/%0d/%0d exp 0/80/80", c, hue_of(c), sat_of(c), val_of(c));
      end
    end
    checks++;
    if (upd_o !== '0 || cmd_if.cmd_ready !== 1'b0 || cmd_if.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl upd %b ready %b err %b exp 0 0 0", upd_o, cmd_if.cmd_ready, cmd_if.cmd_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 0", cmd_if.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got %b exp 1", cmd_if.cmd_ready);
    end
    checks++;
    if (upd_o !== '0 || hue_of(0) !== 0) begin
      errors++;
      $display("FAIL cmd_while_not_ready upd %b hue0 %0d exp 0 0", upd_o, hue_of(0));
    end
    cmd_if.cmd_valid = 1'b0;
    sb_en = 1'b1;
  endtask

  task automatic test_step;
    int n;
    n = cyc + 1;
    sb_push(0, n,      330, 200, 150);
    sb_push(0, n + 10,  30, 200, 150);
    sb_push(0, n + 20,  90, 200, 150);
    cmd_send(0, 1, 330, 200, 150);
    checks++;
    if (hue_of(0) !== 330 || upd_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL step_load hue %0d upd %b exp 330 1", hue_of(0), upd_o[0]);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (hue_of(0) !== 330) begin
      errors++;
      $display("FAIL step_pre_tick hue %0d exp 330", hue_of(0));
    end
    @(negedge clk);
    checks++;
    if (hue_of(0) !== 30) begin
      errors++;
      $display("FAIL step_tick1 hue %0d exp 30", hue_of(0));
    end
    repeat (10) @(negedge clk);
    checks++;
    if (hue_of(0) !== 90) begin
      errors++;
      $display("FAIL step_tick2 hue %0d exp 90", hue_of(0));
    end
    checks++;
    if (hue_of(1) !== 0 || sat_of(1) !== 80 || val_of(1) !== 80) begin
      errors++;
      $display("FAIL step_ch1_untouched got %0d/%0d/%0d exp 0/80/80", hue_of(1), sat_of(1), val_of(1));
    end
    sb_push(0, cyc + 1, 90, 200, 150);
    cmd_send(0, 0, 90, 200, 150);
  endtask

  task automatic test_sweep;
    int n;
    n = cyc + 1;
    sb_push(1, n,     358, 10, 20);
    sb_push(1, n + 4, 359, 10, 20);
    sb_push(1, n + 8,   0, 10, 20);
    cmd_send(1, 2, 358, 10, 20);
    checks++;
    if (cmd_if.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_err got %b exp 0", cmd_if.cmd_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hue_of(1) !== 358) begin
      errors++;
      $display("FAIL sweep_pre_tick hue %0d exp 358", hue_of(1));
    end
    @(negedge clk);
    checks++;
    if (hue_of(1) !== 359) begin
      errors++;
      $display("FAIL sweep_tick1 hue %0d exp 359", hue_of(1));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (hue_of(1) !== 0) begin
      errors++;
      $display("FAIL sweep_wrap hue %0d exp 0", hue_of(1));
    end
    sb_push(1, cyc + 1, 40, 10, 20);
    cmd_send(1, 0, 400, 10, 20);
    checks++;
    if (hue_of(1) !== 40) begin
      errors++;
      $display("FAIL hue_reduce hue %0d exp 40", hue_of(1));
    end
  endtask

  task automatic test_invalid;
    logic [9*CHANNELS-1:0] h0;
    logic [8*CHANNELS-1:0] s0, v0;
    h0 = hue_o; s0 = sat_o; v0 = val_o;
    cmd_send(3, 1, 100, 1, 1);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || upd_o !== '0) begin
      errors++;
      $display("FAIL invalid_err err %b upd %b exp 1 000", cmd_if.cmd_err, upd_o);
    end
    checks++;
    if (hue_o !== h0 || sat_o !== s0 || val_o !== v0) begin
      errors++;
      $display("FAIL invalid_no_change hue %h sat %h val %h exp %h %h %h", hue_o, sat_o, val_o, h0, s0, v0);
    end
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_err_pulse got %b exp 0", cmd_if.cmd_err);
    end
  endtask

  task automatic test_collision;
    int n;
    n = cyc + 1;
    sb_push(2, n, 10, 5, 5);
    cmd_send(2, 2, 10, 5, 5);
    repeat (3) @(negedge clk);
    sb_push(2, n + 4, 200, 5, 5);
    sb_push(2, n + 8, 201, 5, 5);
    cmd_send(2, 2, 200, 5, 5);
    checks++;
    if (hue_of(2) !== 200) begin
      errors++;
      $display("FAIL collide_cmd_wins hue %0d exp 200", hue_of(2));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (hue_of(2) !== 201) begin
      errors++;
      $display("FAIL collide_restart hue %0d exp 201", hue_of(2));
    end
    sb_push(2, cyc + 1, 201, 5, 5);
    cmd_send(2, 0, 201, 5, 5);
  endtask

  task automatic test_back_to_back;
    int n;
    n = cyc + 1;
    sb_push(0, n,      0, 1, 1);
    sb_push(0, n + 4,  1, 1, 1);
    sb_push(0, n + 8,  2, 1, 1);
    sb_push(0, n + 12, 3, 1, 1);
    sb_push(2, n + 1, 77, 7, 7);
    sb_push(1, n + 2,  300, 9, 9);
    sb_push(1, n + 12,   0, 9, 9);
    cmd_send(0, 2, 0, 1, 1);
    cmd_send(2, 0, 77, 7, 7);
    cmd_send(1, 1, 300, 9, 9);
    repeat (10) @(negedge clk);
    checks++;
    if (upd_o[1:0] !== 2'b11 || hue_of(0) !== 3 || hue_of(1) !== 0) begin
      errors++;
      $display("FAIL simultaneous_ticks upd %b h0 %0d h1 %0d exp 11 3 0", upd_o[1:0], hue_of(0), hue_of(1));
    end
    sb_push(0, cyc + 1, 3, 1, 1);
    cmd_send(0, 0, 3, 1, 1);
    sb_push(1, cyc + 1, 0, 9, 9);
    cmd_send(1, 0, 0, 9, 9);
  endtask

  task automatic test_mode3;
    int n;
`ifdef HSV_BREATHE_EN
    int bv[6] = '{2, 1, 0, 1, 2, 1};
    n = cyc + 1;
    for (int k = 0; k < 6; k++) sb_push(2, n + 4 * k, 50, 60, bv[k]);
    cmd_send(2, 3, 50, 60, 2);
    for (int k = 1; k < 6; k++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (val_of(2) !== bv[k] || upd_o[2] !== 1'b1 || hue_of(2) !== 50) begin
        errors++;
        $display("FAIL breathe_step%0d val %0d upd %b hue %0d exp %0d 1 50", k, val_of(2), upd_o[2], hue_of(2), bv[k]);
      end
    end
    sb_push(2, cyc + 1, 50, 60, 1);
    cmd_send(2, 0, 50, 60, 1);
`else
    n = cyc + 1;
    sb_push(2, n, 50, 60, DIM);
    cmd_send(2, 3, 50, 60, 2);
    checks++;
    if (val_of(2) !== DIM || hue_of(2) !== 50 || sat_of(2) !== 60) begin
      errors++;
      $display("FAIL dim_load got %0d/%0d/%0d exp 50/60/%0d", hue_of(2), sat_of(2), val_of(2), DIM);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(negedge clk);
      checks++;
      if (val_of(2) !== DIM || upd_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL dim_hold%0d val %0d upd %b exp %0d 0", k, val_of(2), upd_o[2], DIM);
      end
    end
`endif
  endtask

  task automatic test_reset_mid;
    int n;
    n = cyc + 1;
    sb_push(1, n,     5, 3, 3);
    sb_push(1, n + 4, 6, 3, 3);
    cmd_send(1, 2, 5, 3, 3);
    repeat (5) @(negedge clk);
    checks++;
    if (hue_of(1) !== 6) begin
      errors++;
      $display("FAIL mid_sweep hue %0d exp 6", hue_of(1));
    end
    for (int c = 0; c < CHANNELS; c++) begin
      checks++;
      if (sb_q[c].size() != 0) begin
        errors++;
        $display("FAIL sb_leftover ch%0d pending %0d exp 0", c, sb_q[c].size());
      end
    end
    sb_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (hue_of(1) !== 0 || sat_of(1) !== 80 || val_of(1) !== 80 || cmd_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %0d/%0d/%0d ready %b exp 0/80/80 0",
               hue_of(1), sat_of(1), val_of(1), cmd_if.cmd_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (upd_o !== '0 || hue_of(1) !== 0) begin
        errors++;
        $display("FAIL no_resume cyc %0d upd %b hue %0d exp 000 0", k, upd_o, hue_of(1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_data  = '0;
    test_reset();
    test_step();
    test_sweep();
    test_invalid();
    test_collision();
    test_back_to_back();
    test_mode3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
